// File: rtl/id_scoreboard_pkg.sv
// Shared decode-stage definitions: register addressing and load-latency limits.
package id_scoreboard_pkg;

   localparam int REG_ADDR_W   = 5;
   localparam int REG_NUM_DEF  = 32;
   localparam int LOAD_LAT_MIN = 1;
   localparam int LOAD_LAT_MAX = 7;
   localparam int STALL_CNT_W  = 32;

   // Width of a per-register countdown that must hold values 0..lat.
   function automatic int cnt_width(input int lat);
      return (lat < 1) ? 1 : $clog2(lat + 1);
   endfunction

endpackage

// File: rtl/sb_entry.sv
// One scoreboard slot: counts down the cycles until a pending load result
// for this register becomes forwardable.
module sb_entry
   import id_scoreboard_pkg::*;
#(
   parameter int LOAD_LAT = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic set,
   input  logic clr,
   input  logic hold,
   input  logic flush,
   output logic busy
);

   localparam int             CW      = cnt_width(LOAD_LAT);
   localparam logic [CW-1:0]  LAT_VAL = CW'(LOAD_LAT);

   logic [CW-1:0] cnt_q;

   // Flush beats everything; a new issue beats the countdown; hold freezes it.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_q <= '0;
      end else if (flush) begin
         cnt_q <= '0;
      end else if (set) begin
         cnt_q <= LAT_VAL;
      end else if (clr) begin
         cnt_q <= '0;
      end else if (!hold && (cnt_q != '0)) begin
         cnt_q <= cnt_q - 1'b1;
      end
   end

   assign busy = (cnt_q != '0);

endmodule

// File: rtl/id_scoreboard.sv
// Decode-stage load-use scoreboard: flags reads of registers whose load
// result is not yet forwardable and requests a stall while any port is hit.
// LOAD_LAT must lie in LOAD_LAT_MIN..LOAD_LAT_MAX.
module id_scoreboard
   import id_scoreboard_pkg::*;
#(
   parameter int READ_PORTS = 2,
   parameter int LOAD_LAT   = 2,
   parameter int REG_NUM    = REG_NUM_DEF
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic [READ_PORTS-1:0]            read_en,
   input  logic [REG_ADDR_W*READ_PORTS-1:0] read_addr,
   input  logic                             issue_valid,
   input  logic                             issue_load,
   input  logic                             issue_write_en,
   input  logic [REG_ADDR_W-1:0]            issue_write_addr,
   input  logic                             hold,
   input  logic                             flush,
   output logic [READ_PORTS-1:0]            load_related,
   output logic                             stall_request,
   output logic [STALL_CNT_W-1:0]           stall_count
);

   // Every encodable address gets a busy bit; unimplemented ones and r0 read 0.
   localparam int NSLOT = 1 << REG_ADDR_W;

   logic [NSLOT-1:0]       busy;
   logic                   issue_ok;
   logic                   load_wr;
   logic                   alu_wr;
   logic [READ_PORTS:0]    hit_chain;
   logic [STALL_CNT_W-1:0] stall_cnt_q;

   assign issue_ok = issue_valid && !stall_request && !hold && !flush;
   assign load_wr  = issue_ok && issue_write_en && issue_load && (issue_write_addr != '0);
   // A younger ALU write supersedes a pending load; forwarding covers it.
   assign alu_wr   = issue_ok && issue_write_en && !issue_load;

   for (genvar r = 0; r < NSLOT; r++) begin : g_slot
      if (r == 0 || r >= REG_NUM) begin : g_zero
         assign busy[r] = 1'b0;
      end else begin : g_entry
         sb_entry #(
            .LOAD_LAT (LOAD_LAT)
         ) u_entry (
            .clk   (clk),
            .rst   (rst),
            .set   (load_wr && (issue_write_addr == REG_ADDR_W'(r))),
            .clr   (alu_wr  && (issue_write_addr == REG_ADDR_W'(r))),
            .hold  (hold),
            .flush (flush),
            .busy  (busy[r])
         );
      end
   end

   // Reads see the counters as they stand this cycle, so an instruction that
   // reads its own load destination is checked against the pre-issue state.
   assign hit_chain[0] = 1'b0;
   for (genvar i = 0; i < READ_PORTS; i++) begin : g_port
      logic [REG_ADDR_W-1:0] addr;
      assign addr            = read_addr[REG_ADDR_W*i +: REG_ADDR_W];
      assign load_related[i] = read_en[i] && (addr != '0) && busy[addr];
      assign hit_chain[i+1]  = hit_chain[i] | load_related[i];
   end

   assign stall_request = hit_chain[READ_PORTS];

   // Saturating count of stalled cycles.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         stall_cnt_q <= '0;
      end else if (stall_request && (stall_cnt_q != '1)) begin
         stall_cnt_q <= stall_cnt_q + 1'b1;
      end
   end

   assign stall_count = stall_cnt_q;

endmodule

// File: tb/tb_id_scoreboard.sv
// Directed bench for id_scoreboard with a queue-based scoreboard.
module tb_id_scoreboard;

   localparam int RP  = 3;
   localparam int LAT = 2;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic [RP-1:0] read_en = '0;
   logic [5*RP-1:0] read_addr = '0;
   logic          issue_valid = 1'b0;
   logic          issue_load = 1'b0;
   logic          issue_write_en = 1'b0;
   logic [4:0]    issue_write_addr = '0;
   logic          hold = 1'b0;
   logic          flush = 1'b0;
   logic [RP-1:0] load_related;
   logic          stall_request;
   logic [31:0]   stall_count;

   id_scoreboard #(
      .READ_PORTS (RP),
      .LOAD_LAT   (LAT),
      .REG_NUM    (32)
   ) dut (
      .clk              (clk),
      .rst              (rst),
      .read_en          (read_en),
      .read_addr        (read_addr),
      .issue_valid      (issue_valid),
      .issue_load       (issue_load),
      .issue_write_en   (issue_write_en),
      .issue_write_addr (issue_write_addr),
      .hold             (hold),
      .flush            (flush),
      .load_related     (load_related),
      .stall_request    (stall_request),
      .stall_count      (stall_count)
   );

   always #5 clk = ~clk;

   typedef struct {
      string         nm;
      logic [RP-1:0] lr;
      logic          sr;
      logic [31:0]   sc;
   } exp_t;

   exp_t        exp_q[$];
   exp_t        mon_e;
   int          errors = 0;
   int          checks = 0;
   logic [31:0] exp_sc = '0;

   task automatic chk(input string nm, input string fld, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s.%s: got %0h, expected %0h", nm, fld, act, req);
      end
   endtask

   // One stimulus cycle; expected outputs for this cycle go to the scoreboard.
   task automatic cyc(input string nm, input logic [2:0] ren,
                      input logic [4:0] a0, input logic [4:0] a1, input logic [4:0] a2,
                      input logic iv, input logic il, input logic iwe, input logic [4:0] iwa,
                      input logic h, input logic fl, input logic rb, input logic [2:0] elr);
      exp_t e;
      @(posedge clk);
      #1;
      rst              = rb;
      read_en          = ren;
      read_addr        = {a2, a1, a0};
      issue_valid      = iv;
      issue_load       = il;
      issue_write_en   = iwe;
      issue_write_addr = iwa;
      hold             = h;
      flush            = fl;
      if (!rb) exp_sc = '0;
      e.nm = nm;
      e.lr = elr;
      e.sr = |elr;
      e.sc = exp_sc;
      exp_q.push_back(e);
      if ((|elr) && (exp_sc != 32'hFFFF_FFFF)) exp_sc = exp_sc + 1;
   endtask

   // Monitor: compare whatever the scoreboard expects for this cycle.
   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         mon_e = exp_q.pop_front();
         chk(mon_e.nm, "load_related", 32'(load_related), 32'(mon_e.lr));
         chk(mon_e.nm, "stall_request", 32'(stall_request), 32'(mon_e.sr));
         chk(mon_e.nm, "stall_count", stall_count, mon_e.sc);
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      //  name          ren    a0 a1 a2 iv il we wa  h  fl rb  exp_lr
      cyc("rst_a",      3'b111, 5, 5, 5, 1, 1, 1, 5, 0, 0, 0, 3'b000);
      cyc("rst_b",      3'b111, 5, 5, 5, 1, 1, 1, 5, 0, 0, 0, 3'b000);
      cyc("idle",       3'b000, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 3'b000);

      // load r5 then dependent read: two stalled cycles
      cyc("ld_r5",      3'b000, 0, 0, 0, 1, 1, 1, 5, 0, 0, 1, 3'b000);
      cyc("use_r5_1",   3'b001, 5, 0, 0, 1, 0, 0, 0, 0, 0, 1, 3'b001);
      cyc("use_r5_2",   3'b001, 5, 0, 0, 1, 0, 0, 0, 0, 0, 1, 3'b001);
      cyc("use_r5_3",   3'b001, 5, 0, 0, 1, 0, 0, 0, 0, 0, 1, 3'b000);

      // hold freezes the countdown
      cyc("hld_ld",     3'b000, 0, 0, 0, 1, 1, 1, 5, 0, 0, 1, 3'b000);
      cyc("hld_1",      3'b001, 5, 0, 0, 0, 0, 0, 0, 1, 0, 1, 3'b001);
      cyc("hld_2",      3'b001, 5, 0, 0, 0, 0, 0, 0, 1, 0, 1, 3'b001);
      cyc("hld_3",      3'b001, 5, 0, 0, 0, 0, 0, 0, 1, 0, 1, 3'b001);
      cyc("hld_4",      3'b001, 5, 0, 0, 0, 0, 0, 0, 0, 0, 1, 3'b001);
      cyc("hld_5",      3'b001, 5, 0, 0, 0, 0, 0, 0, 0, 0, 1, 3'b001);
      cyc("hld_6",      3'b001, 5, 0, 0, 0, 0, 0, 0, 0, 0, 1, 3'b000);

      // flush discards the pending load on r7
      cyc("fl_ld",      3'b000, 0, 0, 0, 1, 1, 1, 7, 0, 0, 1, 3'b000);
      cyc("fl_cyc",     3'b001, 7, 0, 0, 0, 0, 0, 0, 0, 1, 1, 3'b001);
      cyc("fl_after",   3'b001, 7, 0, 0, 0, 0, 0, 0, 0, 0, 1, 3'b000);

      // load to r0 never hazards
      cyc("r0_ld",      3'b011, 0, 0, 0, 1, 1, 1, 0, 0, 0, 1, 3'b000);
      cyc("r0_rd",      3'b011, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 3'b000);

      // r3 on ports 0 and 2, ALU write to r3 waits for the stall to clear
      cyc("p3_ld",      3'b000, 0, 0, 0, 1, 1, 1, 3, 0, 0, 1, 3'b000);
      cyc("p3_rd1",     3'b101, 3, 0, 3, 1, 0, 1, 3, 0, 0, 1, 3'b101);
      cyc("p3_rd2",     3'b101, 3, 0, 3, 1, 0, 1, 3, 0, 0, 1, 3'b101);
      cyc("p3_rd3",     3'b101, 3, 0, 3, 1, 0, 1, 3, 0, 0, 1, 3'b000);
      cyc("p3_rd4",     3'b101, 3, 0, 3, 0, 0, 0, 0, 0, 0, 1, 3'b000);

      // ALU write supersedes a pending load
      cyc("alu_ld",     3'b000, 0, 0, 0, 1, 1, 1, 4, 0, 0, 1, 3'b000);
      cyc("alu_wr",     3'b000, 0, 0, 0, 1, 0, 1, 4, 0, 0, 1, 3'b000);
      cyc("alu_rd",     3'b001, 4, 0, 0, 0, 0, 0, 0, 0, 0, 1, 3'b000);

      // read-before-write on own destination
      cyc("rbw_ld",     3'b010, 0, 6, 0, 1, 1, 1, 6, 0, 0, 1, 3'b000);
      cyc("rbw_1",      3'b010, 0, 6, 0, 0, 0, 0, 0, 0, 0, 1, 3'b010);
      cyc("rbw_2",      3'b010, 0, 6, 0, 0, 0, 0, 0, 0, 0, 1, 3'b010);
      cyc("rbw_3",      3'b010, 0, 6, 0, 0, 0, 0, 0, 0, 0, 1, 3'b000);

      // reissued load reloads over the decrement
      cyc("pri_ld1",    3'b000, 0, 0, 0, 1, 1, 1, 8, 0, 0, 1, 3'b000);
      cyc("pri_ld2",    3'b000, 0, 0, 0, 1, 1, 1, 8, 0, 0, 1, 3'b000);
      cyc("pri_rd1",    3'b001, 8, 0, 0, 0, 0, 0, 0, 0, 0, 1, 3'b001);
      cyc("pri_rd2",    3'b001, 8, 0, 0, 0, 0, 0, 0, 0, 0, 1, 3'b001);
      cyc("pri_rd3",    3'b001, 8, 0, 0, 0, 0, 0, 0, 0, 0, 1, 3'b000);

      // flush and hold each block a simultaneous issue
      cyc("fl_iss",     3'b000, 0, 0, 0, 1, 1, 1, 9, 0, 1, 1, 3'b000);
      cyc("fl_iss_rd",  3'b001, 9, 0, 0, 0, 0, 0, 0, 0, 0, 1, 3'b000);
      cyc("hd_iss",     3'b000, 0, 0, 0, 1, 1, 1,10, 1, 0, 1, 3'b000);
      cyc("hd_iss_rd",  3'b001,10, 0, 0, 0, 0, 0, 0, 0, 0, 1, 3'b000);

      // port 2 only, and disabled port ignored
      cyc("p2_ld",      3'b000, 0, 0, 0, 1, 1, 1,11, 0, 0, 1, 3'b000);
      cyc("p2_rd",      3'b101,12, 0,11, 0, 0, 0, 0, 0, 0, 1, 3'b100);
      cyc("ren0_rd",    3'b000,11, 0, 0, 0, 0, 0, 0, 0, 0, 1, 3'b000);
      cyc("quiet",      3'b000, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 3'b000);

      // saturation: preload the counter just below its ceiling
      @(negedge clk);
      #2;
      force dut.stall_cnt_q = 32'hFFFF_FFFE;
      #1;
      release dut.stall_cnt_q;
      exp_sc = 32'hFFFF_FFFE;
      cyc("sat_ld",     3'b000, 0, 0, 0, 1, 1, 1, 5, 0, 0, 1, 3'b000);
      cyc("sat_1",      3'b001, 5, 0, 0, 0, 0, 0, 0, 1, 0, 1, 3'b001);
      cyc("sat_2",      3'b001, 5, 0, 0, 0, 0, 0, 0, 1, 0, 1, 3'b001);
      cyc("sat_3",      3'b001, 5, 0, 0, 0, 0, 0, 0, 1, 0, 1, 3'b001);
      cyc("sat_4",      3'b001, 5, 0, 0, 0, 0, 0, 0, 1, 0, 1, 3'b001);
      // reset mid-stall clears everything without a clock edge
      cyc("rst_mid",    3'b001, 5, 0, 0, 0, 0, 0, 0, 1, 0, 0, 3'b000);
      cyc("rst_post",   3'b001, 5, 0, 0, 0, 0, 0, 0, 0, 0, 1, 3'b000);

      @(negedge clk);
      #1;
      chk("drain", "queue_left", 32'(exp_q.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
